// File: rtl/screen_pkg.sv
// screen_pkg: shared definitions for the screen_* blocks.
// Provides the state and mode encodings, the RGB444 width, the bus widths,
// the pattern select helper and the SCREEN_WDATA framebuffer packing macro.
// DISP_ADDR_WIDTH may be predefined by the display build; it defaults to 17 bits.
`ifndef SCREEN_PKG_SV
`define SCREEN_PKG_SV

`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

// Framebuffer word: RGB444 colour in the low bits, upper bits zero
`define SCREEN_WDATA(c) {20'b0, (c)}

package screen_pkg;

    localparam int unsigned RGB_W   = 12;
    localparam int unsigned WDATA_W = 32;
    localparam int unsigned ADDR_W  = `DISP_ADDR_WIDTH;
    localparam int unsigned KEY_W   = 26;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        FILL         = 3'd1,
        WAIT_RELEASE = 3'd2,
        WAIT_PRESS   = 3'd3,
        DONE         = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_VBAR  = 2'd1,
        MODE_HBAR  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // 0 selects the primary colour, 1 the secondary colour
    function automatic logic pattern_sel(input mode_e m, input logic px, input logic py);
        logic sel;
        sel = 1'b0;
        unique case (m)
            MODE_SOLID: sel = 1'b0;
            MODE_VBAR:  sel = px;
            MODE_HBAR:  sel = py;
            MODE_CHECK: sel = px ^ py;
        endcase
        return sel;
    endfunction

endpackage

`endif

// File: rtl/screen_pattern_if.sv
// screen_pattern_if: sequencer/framebuffer side of screen_pattern.
// master: drives start, mode, key_status, fb_ready; observes fb_we, fb_addr,
//         fb_wdata, busy, screen_done.
// slave:  the pattern block itself (mirror of master).
interface screen_pattern_if;
    import screen_pkg::*;

    logic                 start;
    logic [1:0]           mode;
    logic [KEY_W-1:0]     key_status;
    logic                 fb_ready;
    logic                 fb_we;
    logic [ADDR_W-1:0]    fb_addr;
    logic [WDATA_W-1:0]   fb_wdata;
    logic                 busy;
    logic                 screen_done;

    modport master (
        output start, mode, key_status, fb_ready,
        input  fb_we, fb_addr, fb_wdata, busy, screen_done
    );

    modport slave (
        input  start, mode, key_status, fb_ready,
        output fb_we, fb_addr, fb_wdata, busy, screen_done
    );

endinterface

// File: rtl/screen_key_gate.sv
// screen_key_gate: release-then-press detector for the "press any key" screens.
// Ports: clk, reset (async, active-high); in_release / in_press flag the caller's
// wait states; key_status is one bit per key (1 = pressed).
// to_press_c: all keys released while waiting for release.
// to_done_c:  a key pressed while waiting for a press, or the wait timed out.
// Optional: SCREEN_PATTERN_TIMEOUT_EN adds a wait-cycle counter that forces
// to_done_c when it reaches TIMEOUT-1; without it only a key press completes.
module screen_key_gate
    import screen_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_release,
    input  logic             in_press,
    input  logic [KEY_W-1:0] key_status,
    output logic             to_press_c,
    output logic             to_done_c
);

    logic timeout_c;

`ifdef SCREEN_PATTERN_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_c;

    // Counter is zero whenever outside the wait states, so entry starts at 0
    assign run_c     = in_release | in_press;
    assign timeout_c = run_c && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (run_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_c;

    assign timeout_c = 1'b0;
    assign unused_c  = ^{clk, reset, (TIMEOUT == 32'd0)};
`endif

    assign to_press_c = in_release && (key_status == '0);
    assign to_done_c  = (in_press && (|key_status)) || timeout_c;

endmodule

// File: rtl/screen_pattern.sv
// screen_pattern: fills the framebuffer with a two-colour pattern (solid,
// vertical bars, horizontal bars, checkerboard), then waits for a clean key
// press (all released, then any pressed) and holds screen_done.
// Ports: clk; reset (async, active-high); bus (screen_pattern_if.slave) carrying
// start/mode/key_status/fb_ready in and fb_we/fb_addr/fb_wdata/busy/screen_done out.
// Optional: SCREEN_PATTERN_TIMEOUT_EN enables the TIMEOUT auto-done in screen_key_gate.
module screen_pattern
    import screen_pkg::*;
#(
    parameter int unsigned      H_RES    = 320,
    parameter int unsigned      V_RES    = 240,
    parameter logic [RGB_W-1:0] COLOUR_A = 12'hFF0,
    parameter logic [RGB_W-1:0] COLOUR_B = 12'h00F,
    parameter int unsigned      BAR_W    = 16,
    parameter int unsigned      BAR_H    = 16,
    parameter int unsigned      TIMEOUT  = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    screen_pattern_if.slave bus
);

    localparam int unsigned X_W  = $clog2(H_RES + 1);
    localparam int unsigned Y_W  = $clog2(V_RES + 1);
    localparam int unsigned CX_W = $clog2(BAR_W + 1);
    localparam int unsigned CY_W = $clog2(BAR_H + 1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [X_W-1:0]     x_q, x_d, x_n;
    logic [Y_W-1:0]     y_q, y_d, y_n;
    logic [CX_W-1:0]    cx_q, cx_d, cx_n;
    logic [CY_W-1:0]    cy_q, cy_d, cy_n;
    logic               px_q, px_d, px_n;
    logic               py_q, py_d, py_n;
    logic               fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [RGB_W-1:0]   col_q, col_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_fill_c, accept_c, last_px_c;
    logic               to_press_c, to_done_c;

    screen_key_gate #(
        .TIMEOUT (TIMEOUT)
    ) u_key_gate (
        .clk        (clk),
        .reset      (reset),
        .in_release (state_q == WAIT_RELEASE),
        .in_press   (state_q == WAIT_PRESS),
        .key_status (bus.key_status),
        .to_press_c (to_press_c),
        .to_done_c  (to_done_c)
    );

    // Scan position and cell phase after the current pixel is accepted
    always_comb begin
        x_n  = x_q + X_W'(1);
        y_n  = y_q;
        cx_n = cx_q + CX_W'(1);
        cy_n = cy_q;
        px_n = px_q;
        py_n = py_q;
        if (x_q == X_W'(H_RES - 1)) begin
            // Line start: bar phase restarts, truncating any partial last cell
            x_n  = '0;
            cx_n = '0;
            px_n = 1'b0;
            y_n  = y_q + Y_W'(1);
            if (cy_q == CY_W'(BAR_H - 1)) begin
                cy_n = '0;
                py_n = ~py_q;
            end else begin
                cy_n = cy_q + CY_W'(1);
            end
        end else if (cx_q == CX_W'(BAR_W - 1)) begin
            cx_n = '0;
            px_n = ~px_q;
        end
    end

    assign start_fill_c = bus.start && (state_q != FILL);
    assign accept_c     = fb_we_q && bus.fb_ready;
    assign last_px_c    = (x_q == X_W'(H_RES - 1)) && (y_q == Y_W'(V_RES - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        px_d    = px_q;
        py_d    = py_q;
        fb_we_d = fb_we_q;
        addr_d  = addr_q;
        col_d   = col_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
            end
            FILL: begin
                if (accept_c) begin
                    if (last_px_c) begin
                        fb_we_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = WAIT_RELEASE;
                    end else begin
                        x_d    = x_n;
                        y_d    = y_n;
                        cx_d   = cx_n;
                        cy_d   = cy_n;
                        px_d   = px_n;
                        py_d   = py_n;
                        addr_d = addr_q + ADDR_W'(1);
                        col_d  = pattern_sel(mode_q, px_n, py_n) ? COLOUR_B : COLOUR_A;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (to_done_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (to_press_c) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (to_done_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
                fb_we_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // A new fill overrides any wait or key outcome in the same cycle
        if (start_fill_c) begin
            state_d = FILL;
            mode_d  = mode_e'(bus.mode);
            x_d     = '0;
            y_d     = '0;
            cx_d    = '0;
            cy_d    = '0;
            px_d    = 1'b0;
            py_d    = 1'b0;
            addr_d  = '0;
            col_d   = COLOUR_A;
            fb_we_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_SOLID;
            x_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            px_q    <= 1'b0;
            py_q    <= 1'b0;
            fb_we_q <= 1'b0;
            addr_q  <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            fb_we_q <= fb_we_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.fb_we       = fb_we_q;
    assign bus.fb_addr     = addr_q;
    assign bus.fb_wdata    = `SCREEN_WDATA(col_q);
    assign bus.busy        = busy_q;
    assign bus.screen_done = done_q;

endmodule

// File: tb/tb_screen_pattern.sv
// tb_screen_pattern: directed self-checking bench for screen_pattern on a
// reduced 40x30 frame with 16x16 cells (last cell column truncated).
module tb_screen_pattern;
    import screen_pkg::*;

    localparam int unsigned H    = 40;
    localparam int unsigned V    = 30;
    localparam int unsigned BW   = 16;
    localparam int unsigned BH   = 16;
    localparam int          NPIX = H * V;
    localparam logic [11:0] CA   = 12'hFF0;
    localparam logic [11:0] CB   = 12'h00F;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    screen_pattern_if bus ();

    screen_pattern #(
        .H_RES    (H),
        .V_RES    (V),
        .COLOUR_A (CA),
        .COLOUR_B (CB),
        .BAR_W    (BW),
        .BAR_H    (BH),
        .TIMEOUT  (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference colour computed directly from pixel coordinates
    function automatic logic [31:0] exp_data(input int idx, input logic [1:0] m);
        int   x;
        int   y;
        logic px;
        logic py;
        logic sel;
        x  = idx % H;
        y  = idx / H;
        px = ((x / BW) % 2) == 1;
        py = ((y / BH) % 2) == 1;
        case (m)
            2'd0:    sel = 1'b0;
            2'd1:    sel = px;
            2'd2:    sel = py;
            default: sel = px ^ py;
        endcase
        return {20'b0, (sel ? CB : CA)};
    endfunction

    // Pulse start for one cycle, then scramble mode to show it is latched
    task automatic kick(input logic [1:0] m);
        bus.start = 1'b1;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = ~m;
        check("kick_we", 32'(bus.fb_we), 32'd1);
        check("kick_busy", 32'(bus.busy), 32'd1);
        check("kick_done", 32'(bus.screen_done), 32'd0);
        check("kick_addr", 32'(bus.fb_addr), 32'd0);
        check("kick_data", bus.fb_wdata, exp_data(0, m));
    endtask

    // Accept pixels until the frame completes or abort_at writes were taken
    task automatic drain(input logic [1:0] m, input bit rnd, input int abort_at,
                         input int poke_at, output int nwr);
        int          cyc;
        bit          held;
        bit          poked;
        logic [31:0] hold_a;
        logic [31:0] hold_d;
        cyc   = 0;
        held  = 1'b0;
        poked = 1'b0;
        nwr   = 0;
        hold_a = '0;
        hold_d = '0;
        while (nwr < NPIX) begin
            if (nwr == abort_at) return;
            if (cyc > 8 * NPIX) begin
                check("fill_budget", 32'(nwr), 32'(NPIX));
                return;
            end
            if (held) begin
                check("hold_addr", 32'(bus.fb_addr), hold_a);
                check("hold_data", bus.fb_wdata, hold_d);
            end
            check("fill_we", 32'(bus.fb_we), 32'd1);
            check("fill_busy", 32'(bus.busy), 32'd1);
            bus.start = 1'b0;
            if (nwr == poke_at && !poked) begin
                bus.start = 1'b1;
                poked = 1'b1;
            end
            bus.fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.fb_ready) begin
                check("pix_addr", 32'(bus.fb_addr), 32'(nwr));
                check("pix_data", bus.fb_wdata, exp_data(nwr, m));
                nwr++;
                held = 1'b0;
            end else begin
                held   = 1'b1;
                hold_a = 32'(bus.fb_addr);
                hold_d = bus.fb_wdata;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b0;
        bus.fb_ready = 1'b1;
        check("end_we", 32'(bus.fb_we), 32'd0);
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_done", 32'(bus.screen_done), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.mode       = 2'd0;
        bus.key_status = '0;
        bus.fb_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(bus.fb_we), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.screen_done), 32'd0);
        check("rst_addr", 32'(bus.fb_addr), 32'd0);
        check("rst_data", bus.fb_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_we", 32'(bus.fb_we), 32'd0);
        bus.fb_ready = 1'b1;

        // Solid fill, no keys
        kick(2'd0);
        drain(2'd0, 1'b0, -1, -1, n);
`ifdef SCREEN_PATTERN_TIMEOUT_EN
        repeat (99) @(posedge clk);
        #1;
        check("timeout_early", 32'(bus.screen_done), 32'd0);
        @(posedge clk);
        #1;
        check("timeout_done", 32'(bus.screen_done), 32'd1);
`else
        repeat (150) @(posedge clk);
        #1;
        check("no_timeout", 32'(bus.screen_done), 32'd0);
`endif

        // Checkerboard with a key held across the end of fill
        bus.key_status = 26'(1 << 5);
        kick(2'd3);
        drain(2'd3, 1'b0, -1, -1, n);
        repeat (10) @(posedge clk);
        #1;
        check("held_key", 32'(bus.screen_done), 32'd0);
        bus.key_status = '0;
        @(posedge clk);
        #1;
        check("released", 32'(bus.screen_done), 32'd0);
        bus.key_status = 26'd1;
        @(posedge clk);
        #1;
        check("press_done", 32'(bus.screen_done), 32'd1);
        @(posedge clk);
        #1;
        check("done_level", 32'(bus.screen_done), 32'd1);

        // Vertical bars with a stalling framebuffer and a stray start mid-fill
        kick(2'd1);
        drain(2'd1, 1'b1, -1, 200, n);

        // Start and key press together in WAIT_PRESS: start wins
        bus.key_status = '0;
        @(posedge clk);
        #1;
        bus.key_status = 26'd1;
        kick(2'd2);

        // Reset part-way through, then a clean horizontal-bar fill
        drain(2'd2, 1'b0, 300, -1, n);
        check("abort_count", 32'(n), 32'd300);
        reset = 1'b1;
        #1;
        check("abort_we", 32'(bus.fb_we), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_addr", 32'(bus.fb_addr), 32'd0);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.key_status = '0;
        @(posedge clk);
        #1;
        check("post_rst_we", 32'(bus.fb_we), 32'd0);
        kick(2'd2);
        drain(2'd2, 1'b0, -1, -1, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/screen_pattern.md
Name: screen_pattern

Overview:
- Parametrised successor to the single-colour "press any key" screens.
- Fills the framebuffer with one of four two-colour patterns: solid, vertical bars, horizontal bars, checkerboard. Then waits for a clean key press (all keys released, then any key pressed) and raises screen_done.
- Sits between the screen-sequencer FSM and the display framebuffer write port, alongside the other screen_* blocks.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame; H_RES*V_RES must be ≤ 2**`DISP_ADDR_WIDTH.
- COLOUR_A, 12'hFF0, RGB444 primary colour.
- COLOUR_B, 12'h00F, RGB444 secondary colour.
- BAR_W, 16, bar/cell width in pixels (≥1).
- BAR_H, 16, bar/cell height in lines (≥1).
- TIMEOUT, 50_000_000, auto-done cycle count; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: latch mode and begin a new fill; ignored while FILL is in progress.
- mode  in  2  0 solid A, 1 vertical bars, 2 horizontal bars, 3 checkerboard.
- key_status  in  26  one bit per key, 1 = pressed.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- fb_we  out  1  write request.
- fb_addr  out  `DISP_ADDR_WIDTH  linear pixel address, y*H_RES+x.
- fb_wdata  out  32  {20'b0, RGB444 colour}.
- busy  out  1  high while in FILL.
- screen_done  out  1  level; high in DONE until the next start.

Behaviour:
- Reset values: all outputs 0; state IDLE; x, y and cell counters 0.
- Registered outputs; state encoding and pattern constants come from screen_pkg.
- IDLE: start → latch mode to mode_q, clear counters, go to FILL. fb_we rises on the cycle after start.
- FILL:
  - fb_we=1 and busy=1.
  - Write accepted when fb_we && fb_ready. Only then do x, y, fb_addr and colour advance, on the next edge.
  - fb_ready=0 holds addr and data stable.
  - x wraps at H_RES-1 → 0, and y increments.
  - Accepted write with x=H_RES-1 and y=V_RES-1 → fb_we=0 next cycle; go to WAIT_RELEASE.
  - Exactly H_RES*V_RES writes per fill.
- Colour selection uses no dividers:
  - cx counts 0..BAR_W-1 with x; each wrap toggles px. px resets at each line start.
  - cy counts 0..BAR_H-1 with y; each wrap toggles py.
  - Colour is A when sel=0, B when sel=1, where sel = 0 (solid), px (vertical), py (horizontal), px^py (checker).
- WAIT_RELEASE: key_status==0 → WAIT_PRESS. Keys held from an earlier screen never count as a press.
- WAIT_PRESS: any bit of key_status set → DONE.
- DONE: screen_done=1. start → FILL, clearing screen_done on the same edge as the state change.
- start in WAIT_RELEASE or WAIT_PRESS: abandon the wait and restart the fill with the new mode.
- start and a key press in the same cycle: start wins.
- mode changes during FILL have no effect; mode_q is used.
- Reset mid-fill: immediate return to IDLE with fb_we=0. The partial frame is left as is.
- Non-divisible H_RES/BAR_W: the last cell is simply truncated.

Optional Feature:
- Macro: SCREEN_PATTERN_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_RELEASE and runs during WAIT_RELEASE and WAIT_PRESS.
  - Reaching TIMEOUT-1 forces DONE even without a key.
  - A key press on the same cycle also gives DONE, identical result.
- Undefined: no counter; DONE is reached only by key press.

Decomposition:
- screen_pkg (shared `include header):
  - state encodings IDLE/FILL/WAIT_RELEASE/WAIT_PRESS/DONE;
  - MODE_SOLID/MODE_VBAR/MODE_HBAR/MODE_CHECK;
  - RGB444 width;
  - fb_wdata packing macro.
- Sub-module: screen_key_gate, which holds the release-then-press detector plus the optional timeout counter. It is reusable by screen_solid's successors.
- Scan counters and pattern generation stay in the top.

Test Plan:
- Reset, start with mode=0, fb_ready=1 → 76800 writes, addr 0..76799 contiguous, all data 0x00000FF0, busy falls after the last write, screen_done=0.
- mode=3, BAR_W=BAR_H=16 → pixel (0,0)=FF0, (16,0)=00F, (0,16)=00F, (16,16)=FF0, (319,239)=00F.
- mode=1 with fb_ready toggling pseudo-randomly → addr/data held while fb_ready=0, still exactly 76800 accepted writes, none duplicated or skipped.
- Key 5 held through the fill end → no done; release then press key 0 → screen_done=1 the cycle after the press; start → screen_done=0 and a new fill begins.
- Assert reset at write 1000 → fb_we=0 immediately; after release, start → fill restarts at addr 0.
- With SCREEN_PATTERN_TIMEOUT_EN, TIMEOUT=100 and no keys → screen_done exactly 100 cycles after entering WAIT_RELEASE. Without the macro, screen_done stays 0.
